// File: rtl/regfile_pkg.sv
// Shared parameter limits and address-width helper for the parameterised register file.
// Both the storage top and the pending-bit scoreboard derive AW from the same function.
package regfile_pkg;

   localparam int DATA_W_MIN   = 1;
   localparam int NUM_REGS_MIN = 2;
   localparam int NUM_REGS_MAX = 64;
   localparam int NUM_RD_MIN   = 1;
   localparam int NUM_RD_MAX   = 4;

   // Index width for a power-of-two register count (ceil log2).
   function automatic int addr_w(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 8; i++) begin
         if ((1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

   function automatic bit params_ok(input int data_w, input int num_regs, input int num_rd);
      return (data_w >= DATA_W_MIN) &&
             (num_regs >= NUM_REGS_MIN) && (num_regs <= NUM_REGS_MAX) &&
             ((num_regs & (num_regs - 1)) == 0) &&
             (num_rd >= NUM_RD_MIN) && (num_rd <= NUM_RD_MAX);
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits, pending population counter and double-alloc error pulse.
// set_en/clr_en arrive already filtered (e.g. hardwired-zero register removed by the caller).
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = 16,
   localparam int AW = addr_w(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                set_en,
   input  logic [AW-1:0]       set_addr,
   input  logic                clr_en,
   input  logic [AW-1:0]       clr_addr,
   output logic [NUM_REGS-1:0] pending,
   output logic                alloc_err,
   output logic [AW:0]         pending_cnt
);

   logic                same_idx;
   logic                inc;
   logic                dec;
   logic                err_next;
   logic [NUM_REGS-1:0] pending_next;
   logic [AW:0]         cnt_next;

   // A same-index alloc+write keeps the bit set: set is applied after clear.
   always_comb begin
      same_idx = set_en && clr_en && (set_addr == clr_addr);
      inc      = set_en && !pending[set_addr];
      dec      = clr_en && pending[clr_addr] && !same_idx;
      err_next = set_en && pending[set_addr] && !same_idx;

      pending_next = pending;
      if (clr_en) pending_next[clr_addr] = 1'b0;
      if (set_en) pending_next[set_addr] = 1'b1;

      cnt_next = pending_cnt;
      case ({inc, dec})
         2'b10:   cnt_next = pending_cnt + (AW+1)'(1);
         2'b01:   cnt_next = pending_cnt - (AW+1)'(1);
         default: cnt_next = pending_cnt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending     <= '0;
         alloc_err   <= 1'b0;
         pending_cnt <= '0;
      end else begin
         pending     <= pending_next;
         alloc_err   <= err_next;
         pending_cnt <= cnt_next;
      end
   end

endmodule

// File: rtl/regfile_param.sv
// Parameterised multi-read-port register file with write bypass and operand-ready flags.
// Storage and read muxing live here; pending tracking is in regfile_scoreboard.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 16,
   parameter int NUM_RD   = 2,
   parameter bit ZERO_R0  = 1'b0,
   localparam int AW = addr_w(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [AW-1:0]            wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_ready,
   input  logic                     alloc_en,
   input  logic [AW-1:0]            alloc_addr,
   output logic                     alloc_err,
   output logic [AW:0]              pending_cnt
);

   if (!params_ok(DATA_W, NUM_REGS, NUM_RD)) begin : g_bad_params
      $error("regfile_param: DATA_W/NUM_REGS/NUM_RD out of range");
   end

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] pending;
   logic                wr_ok;
   logic                alloc_ok;

   // With ZERO_R0 the index-0 write/alloc is dropped before it reaches any state.
   assign wr_ok    = wr_en    && !(ZERO_R0 && (wr_addr    == '0));
   assign alloc_ok = alloc_en && !(ZERO_R0 && (alloc_addr == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[wr_addr] <= wr_data;
      end
   end

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .set_en      (alloc_ok),
      .set_addr    (alloc_addr),
      .clr_en      (wr_ok),
      .clr_addr    (wr_addr),
      .pending     (pending),
      .alloc_err   (alloc_err),
      .pending_cnt (pending_cnt)
   );

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [AW-1:0] ra;
      logic          is_zero;
      logic          hit;

      assign ra = rd_addr[p*AW +: AW];

      // Bypass uses the raw strobe so it stays live during reset.
      always_comb begin
         is_zero = ZERO_R0 && (ra == '0);
         hit     = wr_en && (wr_addr == ra) && !is_zero;
         if (is_zero) begin
            rd_data[p*DATA_W +: DATA_W] = '0;
            rd_ready[p]                 = 1'b1;
         end else begin
            rd_data[p*DATA_W +: DATA_W] = hit ? wr_data : regs[ra];
            rd_ready[p]                 = !pending[ra] || hit;
         end
      end
   end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: one default instance and one with a hardwired-zero R0,
// both driven from the same stimulus.
module tb_regfile_param;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic [7:0]  rd_addr;
   logic        alloc_en;
   logic [3:0]  alloc_addr;

   logic [31:0] rd_data,   z_rd_data;
   logic [1:0]  rd_ready,  z_rd_ready;
   logic        alloc_err, z_alloc_err;
   logic [4:0]  pending_cnt, z_pending_cnt;

   int total;
   int bad;

   regfile_param #(
      .DATA_W (16), .NUM_REGS (16), .NUM_RD (2), .ZERO_R0 (1'b0)
   ) dut (
      .clk (clk), .rst (rst), .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
      .rd_addr (rd_addr), .rd_data (rd_data), .rd_ready (rd_ready),
      .alloc_en (alloc_en), .alloc_addr (alloc_addr),
      .alloc_err (alloc_err), .pending_cnt (pending_cnt)
   );

   regfile_param #(
      .DATA_W (16), .NUM_REGS (16), .NUM_RD (2), .ZERO_R0 (1'b1)
   ) dut_z (
      .clk (clk), .rst (rst), .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
      .rd_addr (rd_addr), .rd_data (z_rd_data), .rd_ready (z_rd_ready),
      .alloc_en (alloc_en), .alloc_addr (alloc_addr),
      .alloc_err (z_alloc_err), .pending_cnt (z_pending_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; wr_en = 1'b0; alloc_en = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b0; alloc_en = 1'b0;
      wr_addr = '0; wr_data = '0; alloc_addr = '0; rd_addr = {4'd15, 4'd0};
      tick(); tick();
      rst = 1'b0;
      #1;
      total++; if (pending_cnt !== 5'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", pending_cnt); end
      total++; if (alloc_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", alloc_err); end
      total++; if (rd_ready !== 2'b11) begin bad++; $display("FAIL reset_ready got=%b want=11", rd_ready); end
      total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", rd_data); end
      total++; if (z_pending_cnt !== 5'd0) begin bad++; $display("FAIL reset_z_cnt got=%0d want=0", z_pending_cnt); end
   endtask

   task automatic test_write_read();
      do_reset();
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234; rd_addr = {4'd0, 4'd0};
      tick();
      wr_en = 1'b0; rd_addr = {4'd5, 4'd5};
      #1;
      total++; if (rd_data !== 32'h1234_1234) begin bad++; $display("FAIL wr_rd_data got=%h want=12341234", rd_data); end
      total++; if (rd_ready !== 2'b11) begin bad++; $display("FAIL wr_rd_ready got=%b want=11", rd_ready); end
      total++; if (pending_cnt !== 5'd0) begin bad++; $display("FAIL wr_rd_cnt got=%0d want=0", pending_cnt); end
   endtask

   task automatic test_bypass();
      // R5 still holds 0x1234 from the previous test.
      rd_addr = {4'd5, 4'd3};
      #1;
      total++; if (rd_data[15:0] !== 16'h0000) begin bad++; $display("FAIL byp_pre got=%h want=0000", rd_data[15:0]); end
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
      #1;
      total++; if (rd_data[15:0] !== 16'hBEEF) begin bad++; $display("FAIL byp_p0 got=%h want=beef", rd_data[15:0]); end
      total++; if (rd_data[31:16] !== 16'h1234) begin bad++; $display("FAIL byp_p1 got=%h want=1234", rd_data[31:16]); end
      tick();
      wr_en = 1'b0;
      #1;
      total++; if (rd_data[15:0] !== 16'hBEEF) begin bad++; $display("FAIL byp_stored got=%h want=beef", rd_data[15:0]); end
   endtask

   task automatic test_zero_r0();
      do_reset();
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; rd_addr = {4'd0, 4'd0};
      #1;
      total++; if (z_rd_data[15:0] !== 16'h0000) begin bad++; $display("FAIL z_nobyp got=%h want=0000", z_rd_data[15:0]); end
      total++; if (rd_data[15:0] !== 16'hFFFF) begin bad++; $display("FAIL r0_byp got=%h want=ffff", rd_data[15:0]); end
      tick();
      wr_en = 1'b0;
      #1;
      total++; if (z_rd_data !== 32'h0) begin bad++; $display("FAIL z_read got=%h want=0", z_rd_data); end
      total++; if (z_rd_ready !== 2'b11) begin bad++; $display("FAIL z_ready got=%b want=11", z_rd_ready); end
      total++; if (z_pending_cnt !== 5'd0) begin bad++; $display("FAIL z_cnt got=%0d want=0", z_pending_cnt); end
      total++; if (rd_data[15:0] !== 16'hFFFF) begin bad++; $display("FAIL r0_stored got=%h want=ffff", rd_data[15:0]); end
      alloc_en = 1'b1; alloc_addr = 4'd0;
      tick();
      total++; if (z_pending_cnt !== 5'd0) begin bad++; $display("FAIL z_alloc_cnt got=%0d want=0", z_pending_cnt); end
      total++; if (pending_cnt !== 5'd1) begin bad++; $display("FAIL r0_alloc_cnt got=%0d want=1", pending_cnt); end
      total++; if (rd_ready[0] !== 1'b0) begin bad++; $display("FAIL r0_alloc_ready got=%b want=0", rd_ready[0]); end
      tick();
      alloc_en = 1'b0;
      total++; if (z_alloc_err !== 1'b0) begin bad++; $display("FAIL z_alloc_err got=%b want=0", z_alloc_err); end
      total++; if (alloc_err !== 1'b1) begin bad++; $display("FAIL r0_alloc_err got=%b want=1", alloc_err); end
   endtask

   task automatic test_alloc();
      do_reset();
      alloc_en = 1'b1; alloc_addr = 4'd7; rd_addr = {4'd5, 4'd7};
      tick();
      total++; if (pending_cnt !== 5'd1) begin bad++; $display("FAIL al_cnt1 got=%0d want=1", pending_cnt); end
      total++; if (rd_ready !== 2'b10) begin bad++; $display("FAIL al_ready got=%b want=10", rd_ready); end
      total++; if (alloc_err !== 1'b0) begin bad++; $display("FAIL al_err_first got=%b want=0", alloc_err); end
      tick();
      alloc_en = 1'b0;
      total++; if (alloc_err !== 1'b1) begin bad++; $display("FAIL al_err_dup got=%b want=1", alloc_err); end
      total++; if (pending_cnt !== 5'd1) begin bad++; $display("FAIL al_cnt_dup got=%0d want=1", pending_cnt); end
      tick();
      total++; if (alloc_err !== 1'b0) begin bad++; $display("FAIL al_err_pulse got=%b want=0", alloc_err); end
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0777;
      #1;
      total++; if (rd_ready[0] !== 1'b1) begin bad++; $display("FAIL al_wr_ready got=%b want=1", rd_ready[0]); end
      total++; if (rd_data[15:0] !== 16'h0777) begin bad++; $display("FAIL al_wr_byp got=%h want=0777", rd_data[15:0]); end
      tick();
      wr_en = 1'b0;
      #1;
      total++; if (pending_cnt !== 5'd0) begin bad++; $display("FAIL al_cnt0 got=%0d want=0", pending_cnt); end
      total++; if (rd_ready[0] !== 1'b1) begin bad++; $display("FAIL al_ready_after got=%b want=1", rd_ready[0]); end
   endtask

   task automatic test_alloc_write_same();
      do_reset();
      alloc_en = 1'b1; alloc_addr = 4'd2;
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h0042; rd_addr = {4'd0, 4'd2};
      tick();
      alloc_en = 1'b0; wr_en = 1'b0;
      #1;
      total++; if (rd_data[15:0] !== 16'h0042) begin bad++; $display("FAIL aw_data got=%h want=0042", rd_data[15:0]); end
      total++; if (rd_ready[0] !== 1'b0) begin bad++; $display("FAIL aw_ready got=%b want=0", rd_ready[0]); end
      total++; if (pending_cnt !== 5'd1) begin bad++; $display("FAIL aw_cnt got=%0d want=1", pending_cnt); end
      total++; if (alloc_err !== 1'b0) begin bad++; $display("FAIL aw_err got=%b want=0", alloc_err); end
   endtask

   task automatic test_counter_mixed();
      do_reset();
      alloc_en = 1'b1; alloc_addr = 4'd10;
      tick();
      alloc_addr = 4'd11; wr_en = 1'b1; wr_addr = 4'd10; wr_data = 16'hA0A0;
      tick();
      alloc_en = 1'b0; wr_en = 1'b0; rd_addr = {4'd11, 4'd10};
      #1;
      total++; if (pending_cnt !== 5'd1) begin bad++; $display("FAIL mix_cnt got=%0d want=1", pending_cnt); end
      total++; if (rd_ready !== 2'b01) begin bad++; $display("FAIL mix_ready got=%b want=01", rd_ready); end
      wr_en = 1'b1; wr_addr = 4'd12; wr_data = 16'h5A5A;
      tick();
      wr_en = 1'b0; rd_addr = {4'd12, 4'd10};
      #1;
      total++; if (pending_cnt !== 5'd1) begin bad++; $display("FAIL np_cnt got=%0d want=1", pending_cnt); end
      total++; if (rd_data !== 32'h5A5A_A0A0) begin bad++; $display("FAIL np_data got=%h want=5a5aa0a0", rd_data); end
   endtask

   task automatic test_reset_priority();
      do_reset();
      wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'h1111;
      tick();
      wr_en = 1'b0; alloc_en = 1'b1;
      alloc_addr = 4'd1; tick();
      alloc_addr = 4'd4; tick();
      alloc_addr = 4'd9; tick();
      alloc_en = 1'b0;
      total++; if (pending_cnt !== 5'd3) begin bad++; $display("FAIL rp_cnt3 got=%0d want=3", pending_cnt); end
      rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'hAAAA;
      alloc_en = 1'b1; alloc_addr = 4'd1; rd_addr = {4'd1, 4'd4};
      #1;
      total++; if (rd_data !== 32'h1111_AAAA) begin bad++; $display("FAIL rp_byp got=%h want=1111aaaa", rd_data); end
      tick();
      rst = 1'b0; wr_en = 1'b0; alloc_en = 1'b0;
      #1;
      total++; if (pending_cnt !== 5'd0) begin bad++; $display("FAIL rp_cnt got=%0d want=0", pending_cnt); end
      total++; if (alloc_err !== 1'b0) begin bad++; $display("FAIL rp_err got=%b want=0", alloc_err); end
      total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL rp_data got=%h want=0", rd_data); end
      total++; if (rd_ready !== 2'b11) begin bad++; $display("FAIL rp_ready got=%b want=11", rd_ready); end
      rd_addr = {4'd9, 4'd9};
      #1;
      total++; if (rd_ready !== 2'b11) begin bad++; $display("FAIL rp_ready9 got=%b want=11", rd_ready); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_write_read();
      test_bypass();
      test_zero_r0();
      test_alloc();
      test_alloc_write_same();
      test_counter_mixed();
      test_reset_priority();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
